mc_control: RTL and testbench

Multi-cycle control unit for the MIPS subset core: it decodes the instruction word and sequences datapath control over several cycles instead of one. It adds wait-state handshakes to instruction and data memory, and a counted multi-cycle MULTU that writes HI/LO. It sits between instruction register, memory interface and datapath, and replaces the single-cycle decoder in the multi-cycle core.

---
 rtl/mc_pkg.sv | 59 +++++
 rtl/mc_control_if.sv | 36 +++
 rtl/mc_decode.sv | 53 +++++
 rtl/mc_control.sv | 222 ++++++++++++++++++++++
 tb/tb_mc_control.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset controller: opcodes,
// function codes, ALU encodings, FSM states and instruction classes.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_MFHI   = 6'h10;
    localparam logic [5:0] FN_MFLO   = 6'h12;
    localparam logic [5:0] FN_MULTU  = 6'h19;
    localparam logic [5:0] FN_ADDU   = 6'h21;
    localparam logic [5:0] FN_SUBU   = 6'h23;
    localparam logic [5:0] FN_AND    = 6'h24;
    localparam logic [5:0] FN_OR     = 6'h25;
    localparam logic [5:0] FN_SLTU   = 6'h2B;

    localparam logic [2:0] ALU_ADDU  = 3'b101;
    localparam logic [2:0] ALU_SUBU  = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b111;
    localparam logic [2:0] ALU_OR    = 3'b110;
    localparam logic [2:0] ALU_SLTU  = 3'b000;
    localparam logic [2:0] ALU_MULTU = 3'b100;
    localparam logic [2:0] ALU_LUI   = 3'b011;
    localparam logic [2:0] ALU_BLTZ  = 3'b010;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_MULWAIT = 3'd5,
        ST_HALT    = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        CL_ILLEGAL = 4'd0,
        CL_RALU    = 4'd1,
        CL_IALU    = 4'd2,
        CL_LW      = 4'd3,
        CL_SW      = 4'd4,
        CL_BEQ     = 4'd5,
        CL_BLTZ    = 4'd6,
        CL_J       = 4'd7,
        CL_JAL     = 4'd8,
        CL_JR      = 4'd9,
        CL_MULTU   = 4'd10
    } iclass_e;

endpackage

// File: rtl/mc_control_if.sv
// Controller <-> datapath/memory signal bundle; the controller uses the
// master modport, the datapath/memory side the slave modport.
interface mc_control_if #(
    parameter int REG_AW = 5
);
    logic [31:0]       instr;
    logic              zero;
    logic              memready;
    logic              memreq;
    logic              irwrite;
    logic              pcwrite;
    logic              memtoreg;
    logic              memwrite;
    logic              dobranch;
    logic              alusrcbimm;
    logic              regwrite;
    logic              dojump;
    logic [REG_AW-1:0] destreg;
    logic [2:0]        alucontrol;
    logic              hilowrite;
    logic              illegal;

    modport master (
        input  instr, zero, memready,
        output memreq, irwrite, pcwrite, memtoreg, memwrite, dobranch,
               alusrcbimm, regwrite, dojump, destreg, alucontrol,
               hilowrite, illegal
    );

    modport slave (
        output instr, zero, memready,
        input  memreq, irwrite, pcwrite, memtoreg, memwrite, dobranch,
               alusrcbimm, regwrite, dojump, destreg, alucontrol,
               hilowrite, illegal
    );
endinterface

// File: rtl/mc_decode.sv
// Combinational opcode/funct decoder: instruction class and ALU operation.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic [4:0] rt_i,
    output iclass_e    class_o,
    output logic [2:0] alu_o
);

    // Class and ALU op lookup; anything unmatched stays CL_ILLEGAL.
    always_comb begin
        class_o = CL_ILLEGAL;
        alu_o   = ALU_SLTU;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU:  begin class_o = CL_RALU;  alu_o = ALU_ADDU;  end
                    FN_SUBU:  begin class_o = CL_RALU;  alu_o = ALU_SUBU;  end
                    FN_AND:   begin class_o = CL_RALU;  alu_o = ALU_AND;   end
                    FN_OR:    begin class_o = CL_RALU;  alu_o = ALU_OR;    end
                    FN_SLTU:  begin class_o = CL_RALU;  alu_o = ALU_SLTU;  end
                    FN_MFHI,
                    FN_MFLO:  begin class_o = CL_RALU;  alu_o = ALU_ADDU;  end
                    FN_MULTU: begin class_o = CL_MULTU; alu_o = ALU_MULTU; end
                    FN_JR:    begin class_o = CL_JR;    alu_o = ALU_SLTU;  end
                    default:  begin class_o = CL_ILLEGAL; alu_o = ALU_SLTU; end
                endcase
            end
            OP_REGIMM: begin
                // Only BLTZ (rt == 0) exists in this subset.
                if (rt_i == 5'd0) begin
                    class_o = CL_BLTZ;
                    alu_o   = ALU_BLTZ;
                end else begin
                    class_o = CL_ILLEGAL;
                    alu_o   = ALU_SLTU;
                end
            end
            OP_J:     begin class_o = CL_J;    alu_o = ALU_SLTU; end
            OP_JAL:   begin class_o = CL_JAL;  alu_o = ALU_ADDU; end
            OP_BEQ:   begin class_o = CL_BEQ;  alu_o = ALU_SUBU; end
            OP_ADDIU: begin class_o = CL_IALU; alu_o = ALU_ADDU; end
            OP_ORI:   begin class_o = CL_IALU; alu_o = ALU_OR;   end
            OP_LUI:   begin class_o = CL_IALU; alu_o = ALU_LUI;  end
            OP_LW:    begin class_o = CL_LW;   alu_o = ALU_ADDU; end
            OP_SW:    begin class_o = CL_SW;   alu_o = ALU_ADDU; end
            default:  begin class_o = CL_ILLEGAL; alu_o = ALU_SLTU; end
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM with memory wait states and counted MULTU.
// Optional macro MC_ILLEGAL_TRAP_EN: illegal instructions halt until reset.
module mc_control
    import mc_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int REG_AW     = 5,
    parameter int LINK_REG   = 31
) (
    input  logic         clk,
    input  logic         reset,
    mc_control_if.master bus
);

    localparam int              CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [5:0]        op_q, op_d, funct_q, funct_d;
    logic [4:0]        rt_q, rt_d, rd_q, rd_d;

    logic [5:0]        dec_op_s, dec_funct_s;
    logic [4:0]        dec_rt_s;
    iclass_e           class_s;
    logic [2:0]        alu_s;

    logic              memreq_s, irwrite_s, pcwrite_s, memtoreg_s, memwrite_s;
    logic              dobranch_s, alusrcbimm_s, regwrite_s, dojump_s;
    logic              hilowrite_s, illegal_s;
    logic [REG_AW-1:0] destreg_s;
    logic [2:0]        alucontrol_s;
    logic              unused_s;

    assign unused_s = ^{bus.instr[25:21], bus.instr[10:6]};

    // DECODE classifies the live word; later states use the latched fields.
    always_comb begin
        if (state_q == ST_DECODE) begin
            dec_op_s    = bus.instr[31:26];
            dec_funct_s = bus.instr[5:0];
            dec_rt_s    = bus.instr[20:16];
        end else begin
            dec_op_s    = op_q;
            dec_funct_s = funct_q;
            dec_rt_s    = rt_q;
        end
    end

    mc_decode u_decode (
        .op_i    (dec_op_s),
        .funct_i (dec_funct_s),
        .rt_i    (dec_rt_s),
        .class_o (class_s),
        .alu_o   (alu_s)
    );

    // State, MULTU counter and instruction field registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
            op_q    <= 6'd0;
            funct_q <= 6'd0;
            rt_q    <= 5'd0;
            rd_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            funct_q <= funct_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
        end
    end

    // Next state and Moore/Mealy controls; reset forces every output low.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        funct_d      = funct_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        memreq_s     = 1'b0;
        irwrite_s    = 1'b0;
        pcwrite_s    = 1'b0;
        memtoreg_s   = 1'b0;
        memwrite_s   = 1'b0;
        dobranch_s   = 1'b0;
        alusrcbimm_s = 1'b0;
        regwrite_s   = 1'b0;
        dojump_s     = 1'b0;
        hilowrite_s  = 1'b0;
        illegal_s    = 1'b0;
        destreg_s    = '0;
        alucontrol_s = 3'b000;
        if (reset) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    memreq_s = 1'b1;
                    if (bus.memready) begin
                        irwrite_s = 1'b1;
                        pcwrite_s = 1'b1;
                        state_d   = ST_DECODE;
                    end else begin
                        state_d   = ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    op_d    = bus.instr[31:26];
                    funct_d = bus.instr[5:0];
                    rt_d    = bus.instr[20:16];
                    rd_d    = bus.instr[15:11];
                    if (class_s == CL_ILLEGAL) begin
                        illegal_s = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
                        state_d   = ST_HALT;
`else
                        state_d   = ST_FETCH;
`endif
                    end else begin
                        state_d   = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (class_s)
                        CL_RALU: begin
                            alucontrol_s = alu_s;
                            state_d      = ST_WB;
                        end
                        CL_IALU: begin
                            alucontrol_s = alu_s;
                            alusrcbimm_s = 1'b1;
                            state_d      = ST_WB;
                        end
                        CL_LW, CL_SW: begin
                            alucontrol_s = ALU_ADDU;
                            alusrcbimm_s = 1'b1;
                            state_d      = ST_MEM;
                        end
                        CL_BEQ, CL_BLTZ: begin
                            alucontrol_s = alu_s;
                            dobranch_s   = bus.zero;
                            state_d      = ST_FETCH;
                        end
                        CL_J, CL_JR: begin
                            dojump_s = 1'b1;
                            state_d  = ST_FETCH;
                        end
                        CL_JAL: begin
                            dojump_s     = 1'b1;
                            regwrite_s   = 1'b1;
                            destreg_s    = REG_AW'(LINK_REG);
                            alucontrol_s = ALU_ADDU;
                            state_d      = ST_FETCH;
                        end
                        CL_MULTU: begin
                            alucontrol_s = ALU_MULTU;
                            cnt_d        = CNT_LOAD;
                            state_d      = ST_MULWAIT;
                        end
                        default: begin
                            state_d = ST_FETCH;
                        end
                    endcase
                end
                ST_MEM: begin
                    memreq_s   = 1'b1;
                    memwrite_s = (class_s == CL_SW);
                    if (bus.memready) begin
                        state_d = (class_s == CL_LW) ? ST_WB : ST_FETCH;
                    end else begin
                        state_d = ST_MEM;
                    end
                end
                ST_WB: begin
                    regwrite_s = 1'b1;
                    memtoreg_s = (class_s == CL_LW);
                    destreg_s  = (class_s == CL_RALU) ? REG_AW'(rd_q) : REG_AW'(rt_q);
                    state_d    = ST_FETCH;
                end
                ST_MULWAIT: begin
                    if (cnt_q == '0) begin
                        hilowrite_s = 1'b1;
                        state_d     = ST_FETCH;
                    end else begin
                        cnt_d       = cnt_q - CNT_W'(1);
                    end
                end
                ST_HALT: begin
`ifdef MC_ILLEGAL_TRAP_EN
                    illegal_s = 1'b1;
                    state_d   = ST_HALT;
`else
                    state_d   = ST_FETCH;
`endif
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    assign bus.memreq     = memreq_s;
    assign bus.irwrite    = irwrite_s;
    assign bus.pcwrite    = pcwrite_s;
    assign bus.memtoreg   = memtoreg_s;
    assign bus.memwrite   = memwrite_s;
    assign bus.dobranch   = dobranch_s;
    assign bus.alusrcbimm = alusrcbimm_s;
    assign bus.regwrite   = regwrite_s;
    assign bus.dojump     = dojump_s;
    assign bus.hilowrite  = hilowrite_s;
    assign bus.illegal    = illegal_s;
    assign bus.destreg    = destreg_s;
    assign bus.alucontrol = alucontrol_s;

endmodule

// File: tb/tb_mc_control.sv
// Table-driven cycle-by-cycle bench for mc_control plus a MULTU timing sequence.
module tb_mc_control;

    localparam int MUL_CYCLES = 4;
    localparam int REG_AW     = 5;
    localparam int LINK_REG   = 31;

    localparam logic [10:0] M_MREQ = 11'h400;
    localparam logic [10:0] M_IRW  = 11'h200;
    localparam logic [10:0] M_PCW  = 11'h100;
    localparam logic [10:0] M_M2R  = 11'h080;
    localparam logic [10:0] M_MEMW = 11'h040;
    localparam logic [10:0] M_BR   = 11'h020;
    localparam logic [10:0] M_IMM  = 11'h010;
    localparam logic [10:0] M_RW   = 11'h008;
    localparam logic [10:0] M_JMP  = 11'h004;
    localparam logic [10:0] M_HILO = 11'h002;
    localparam logic [10:0] M_ILL  = 11'h001;
    localparam logic [10:0] M_NONE = 11'h000;
    localparam logic [10:0] M_FET  = M_MREQ | M_IRW | M_PCW;

    localparam logic [31:0] I_ADDU  = 32'h0022_1821;
    localparam logic [31:0] I_SLTU  = 32'h0022_202B;
    localparam logic [31:0] I_LW    = 32'h8C85_0008;
    localparam logic [31:0] I_SW    = 32'hAC85_0008;
    localparam logic [31:0] I_MULTU = 32'h0022_0019;
    localparam logic [31:0] I_BEQ   = 32'h1022_0004;
    localparam logic [31:0] I_BLTZ  = 32'h0420_0004;
    localparam logic [31:0] I_JAL   = 32'h0C00_0100;
    localparam logic [31:0] I_J     = 32'h0800_0010;
    localparam logic [31:0] I_JR    = 32'h03E0_0008;
    localparam logic [31:0] I_ADDIU = 32'h2427_0005;
    localparam logic [31:0] I_LUI   = 32'h3C08_1234;
    localparam logic [31:0] I_ORI   = 32'h3429_0001;
    localparam logic [31:0] I_ILL   = 32'hFC00_0000;

    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] instr;
        logic        zero;
        logic        rdy;
        logic [10:0] ctl;
        logic [4:0]  dest;
        logic [2:0]  alu;
    } vec_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    vec_t tbl[$];

    mc_control_if #(.REG_AW(REG_AW)) bus ();

    mc_control #(
        .MUL_CYCLES (MUL_CYCLES),
        .REG_AW     (REG_AW),
        .LINK_REG   (LINK_REG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input string nm, input logic r, input logic [31:0] ins,
                       input logic z, input logic rd, input logic [10:0] c,
                       input logic [4:0] d, input logic [2:0] a);
        vec_t v;
        v.name = nm; v.rst = r; v.instr = ins; v.zero = z; v.rdy = rd;
        v.ctl = c; v.dest = d; v.alu = a;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Standard fetch + decode pair for a legal instruction.
    task automatic fd(input string nm, input logic [31:0] ins);
        add({nm, "_fetch"},  1'b0, ins, 1'b0, 1'b1, M_FET,  5'd0, 3'b000);
        add({nm, "_decode"}, 1'b0, ins, 1'b0, 1'b1, M_NONE, 5'd0, 3'b000);
    endtask

    logic [18:0] act_s;
    assign act_s = {bus.memreq, bus.irwrite, bus.pcwrite, bus.memtoreg, bus.memwrite,
                    bus.dobranch, bus.alusrcbimm, bus.regwrite, bus.dojump,
                    bus.hilowrite, bus.illegal, bus.destreg, bus.alucontrol};

    initial begin
        int len;
        int hilo_cnt;
        int regw_cnt;
        errors = 0;
        checks = 0;

        add("reset0", 1'b1, I_ADDU, 1'b0, 1'b0, M_NONE, 5'd0, 3'b000);
        add("reset1", 1'b1, I_ADDU, 1'b0, 1'b1, M_NONE, 5'd0, 3'b000);
        fd("addu", I_ADDU);
        add("addu_exec", 1'b0, I_ADDU, 1'b0, 1'b1, M_NONE, 5'd0, 3'b101);
        add("addu_wb",   1'b0, I_ADDU, 1'b0, 1'b1, M_RW,   5'd3, 3'b000);
        fd("lw", I_LW);
        add("lw_exec", 1'b0, I_LW, 1'b0, 1'b1, M_IMM,          5'd0, 3'b101);
        add("lw_mem0", 1'b0, I_LW, 1'b0, 1'b0, M_MREQ,         5'd0, 3'b000);
        add("lw_mem1", 1'b0, I_LW, 1'b0, 1'b0, M_MREQ,         5'd0, 3'b000);
        add("lw_mem2", 1'b0, I_LW, 1'b0, 1'b1, M_MREQ,         5'd0, 3'b000);
        add("lw_wb",   1'b0, I_LW, 1'b0, 1'b1, M_RW | M_M2R,   5'd5, 3'b000);
        add("sw_fetchwait", 1'b0, I_SW, 1'b0, 1'b0, M_MREQ, 5'd0, 3'b000);
        add("sw_fetch",     1'b0, I_SW, 1'b0, 1'b1, M_FET,  5'd0, 3'b000);
        add("sw_decode",    1'b0, I_SW, 1'b0, 1'b1, M_NONE, 5'd0, 3'b000);
        add("sw_exec",      1'b0, I_SW, 1'b0, 1'b1, M_IMM,  5'd0, 3'b101);
        add("sw_mem",       1'b0, I_SW, 1'b0, 1'b1, M_MREQ | M_MEMW, 5'd0, 3'b000);
        fd("multu", I_MULTU);
        add("multu_exec", 1'b0, I_MULTU, 1'b0, 1'b1, M_NONE, 5'd0, 3'b100);
        add("multu_w1",   1'b0, I_MULTU, 1'b0, 1'b1, M_NONE, 5'd0, 3'b000);
        add("multu_w2",   1'b0, I_MULTU, 1'b0, 1'b1, M_NONE, 5'd0, 3'b000);
        add("multu_w3",   1'b0, I_MULTU, 1'b0, 1'b1, M_NONE, 5'd0, 3'b000);
        add("multu_w4",   1'b0, I_MULTU, 1'b0, 1'b1, M_HILO, 5'd0, 3'b000);
        fd("beq1", I_BEQ);
        add("beq1_exec", 1'b0, I_BEQ, 1'b1, 1'b1, M_BR,   5'd0, 3'b001);
        fd("beq0", I_BEQ);
        add("beq0_exec", 1'b0, I_BEQ, 1'b0, 1'b1, M_NONE, 5'd0, 3'b001);
        fd("jal", I_JAL);
        add("jal_exec",  1'b0, I_JAL, 1'b0, 1'b1, M_JMP | M_RW, 5'd31, 3'b101);
        fd("bltz", I_BLTZ);
        add("bltz_exec", 1'b0, I_BLTZ, 1'b1, 1'b1, M_BR, 5'd0, 3'b010);
        fd("addiu", I_ADDIU);
        add("addiu_exec", 1'b0, I_ADDIU, 1'b0, 1'b1, M_IMM, 5'd0, 3'b101);
        add("addiu_wb",   1'b0, I_ADDIU, 1'b0, 1'b1, M_RW,  5'd7, 3'b000);
        fd("lui", I_LUI);
        add("lui_exec", 1'b0, I_LUI, 1'b0, 1'b1, M_IMM, 5'd0, 3'b011);
        add("lui_wb",   1'b0, I_LUI, 1'b0, 1'b1, M_RW,  5'd8, 3'b000);
        fd("ori", I_ORI);
        add("ori_exec", 1'b0, I_ORI, 1'b0, 1'b1, M_IMM, 5'd0, 3'b110);
        add("ori_wb",   1'b0, I_ORI, 1'b0, 1'b1, M_RW,  5'd9, 3'b000);
        fd("sltu", I_SLTU);
        add("sltu_exec", 1'b0, I_SLTU, 1'b0, 1'b1, M_NONE, 5'd0, 3'b000);
        add("sltu_wb",   1'b0, I_SLTU, 1'b0, 1'b1, M_RW,   5'd4, 3'b000);
        fd("j", I_J);
        add("j_exec",  1'b0, I_J,  1'b0, 1'b1, M_JMP, 5'd0, 3'b000);
        fd("jr", I_JR);
        add("jr_exec", 1'b0, I_JR, 1'b0, 1'b1, M_JMP, 5'd0, 3'b000);
        // Reset during the second MULWAIT cycle aborts the multiply.
        fd("mrst", I_MULTU);
        add("mrst_exec", 1'b0, I_MULTU, 1'b0, 1'b1, M_NONE, 5'd0, 3'b100);
        add("mrst_w1",   1'b0, I_MULTU, 1'b0, 1'b1, M_NONE, 5'd0, 3'b000);
        add("mrst_rst",  1'b1, I_MULTU, 1'b0, 1'b1, M_NONE, 5'd0, 3'b000);
        add("mrst_fw",   1'b0, I_J,     1'b0, 1'b0, M_MREQ, 5'd0, 3'b000);
        add("mrst_f",    1'b0, I_J,     1'b0, 1'b1, M_FET,  5'd0, 3'b000);
        add("mrst_d",    1'b0, I_J,     1'b0, 1'b1, M_NONE, 5'd0, 3'b000);
        add("mrst_e",    1'b0, I_J,     1'b0, 1'b1, M_JMP,  5'd0, 3'b000);
        // Reset while a store waits in MEM: no write may follow.
        fd("srst", I_SW);
        add("srst_exec", 1'b0, I_SW,   1'b0, 1'b1, M_IMM, 5'd0, 3'b101);
        add("srst_mem",  1'b0, I_SW,   1'b0, 1'b0, M_MREQ | M_MEMW, 5'd0, 3'b000);
        add("srst_rst",  1'b1, I_SW,   1'b0, 1'b1, M_NONE, 5'd0, 3'b000);
        add("srst_f",    1'b0, I_ADDU, 1'b0, 1'b1, M_FET,  5'd0, 3'b000);
        add("srst_d",    1'b0, I_ADDU, 1'b0, 1'b1, M_NONE, 5'd0, 3'b000);
        add("srst_e",    1'b0, I_ADDU, 1'b0, 1'b1, M_NONE, 5'd0, 3'b101);
        add("srst_wb",   1'b0, I_ADDU, 1'b0, 1'b1, M_RW,   5'd3, 3'b000);
        add("ill_fetch",  1'b0, I_ILL, 1'b0, 1'b1, M_FET, 5'd0, 3'b000);
        add("ill_decode", 1'b0, I_ILL, 1'b0, 1'b1, M_ILL, 5'd0, 3'b000);
`ifdef MC_ILLEGAL_TRAP_EN
        add("ill_halt0", 1'b0, I_ILL,  1'b0, 1'b1, M_ILL,  5'd0, 3'b000);
        add("ill_halt1", 1'b0, I_ADDU, 1'b0, 1'b1, M_ILL,  5'd0, 3'b000);
        add("ill_rst",   1'b1, I_ADDU, 1'b0, 1'b1, M_NONE, 5'd0, 3'b000);
        add("ill_after", 1'b0, I_ADDU, 1'b0, 1'b1, M_FET,  5'd0, 3'b000);
`else
        add("ill_next_fetch", 1'b0, I_ADDU, 1'b0, 1'b1, M_FET,  5'd0, 3'b000);
        add("ill_next_dec",   1'b0, I_ADDU, 1'b0, 1'b1, M_NONE, 5'd0, 3'b000);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            reset        = tbl[i].rst;
            bus.instr    = tbl[i].instr;
            bus.zero     = tbl[i].zero;
            bus.memready = tbl[i].rdy;
            @(negedge clk);
            check(tbl[i].name, {13'd0, act_s}, {13'd0, tbl[i].ctl, tbl[i].dest, tbl[i].alu});
            @(posedge clk);
            #1;
        end

        // MULTU end to end: length, single hilowrite, no regwrite.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.instr    = I_MULTU;
        bus.zero     = 1'b0;
        bus.memready = 1'b1;
        len      = 0;
        hilo_cnt = 0;
        regw_cnt = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (bus.irwrite && k > 1) begin
                len = k - 1;
                break;
            end
            if (bus.hilowrite) hilo_cnt++;
            if (bus.regwrite)  regw_cnt++;
            @(posedge clk);
            #1;
        end
        check("multu_length",   32'(len),      32'(3 + MUL_CYCLES));
        check("multu_hilo_cnt", 32'(hilo_cnt), 32'd1);
        check("multu_regwrite", 32'(regw_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
